// File: rtl/eth_stream_fcs_checker_pkg.sv
// Shared eth-stream types, CRC-32 constants and helpers.
// Used by the FCS checker, its CRC sub-module and the stream interface.
package eth_stream_pkg;

  typedef logic [1:0] eth_keep_t;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

  // Reflected CRC-32, one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data_byte);
    logic [31:0] c;
    c = crc ^ {24'h0, data_byte};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/eth_stream_fcs_checker_if.sv
// Eth-stream beat bundle: 32-bit data, last-beat keep, valid/last/abort.
// No ready signal; the sink takes every valid beat.
interface eth_stream_fcs_checker_if;
  import eth_stream_pkg::*;

  logic [31:0] data;
  eth_keep_t   keep;
  logic        valid;
  logic        last;
  logic        abort;

  modport master (output data, keep, valid, last, abort);
  modport slave  (input  data, keep, valid, last, abort);

endinterface

// File: rtl/eth_stream_fcs_checker_crc.sv
// Running FCS register; next value and residue match are combinational
// over the beat being accepted (4 bytes, or keep+1 on a last beat).
module eth_fcs_crc32
  import eth_stream_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_init,
  input  logic        i_en,
  input  logic        i_last,
  input  logic [31:0] i_data,
  input  eth_keep_t   i_keep,
  output logic [31:0] o_crc_next,
  output logic        o_match
);

  logic [31:0] crc;

  always_comb begin
    o_crc_next = crc;
    for (int i = 0; i < 4; i++) begin
      if (!i_last || i <= int'(i_keep)) begin
        o_crc_next = crc32_byte(o_crc_next, i_data[8*i +: 8]);
      end
    end
    o_match = (o_crc_next == CRC32_RESIDUE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      crc <= CRC32_INIT;
    end else if (i_en) begin
      crc <= i_init ? CRC32_INIT : o_crc_next;
    end
  end

endmodule

// File: rtl/eth_stream_fcs_checker.sv
// Checks and strips the Ethernet FCS; bad packets end with abort=1.
// One-beat hold line, registered outputs, no backpressure, saturating stats.
module eth_stream_fcs_checker
  import eth_stream_pkg::*;
#(
  parameter int DATAPATH_WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  eth_stream_fcs_checker_if.slave  eths_slave,
  eth_stream_fcs_checker_if.master eths_master,
  output logic [31:0]              o_good_count,
  output logic [31:0]              o_bad_fcs_count,
  output logic [31:0]              o_runt_count,
  output logic [31:0]              o_abort_count
);

  if (DATAPATH_WIDTH != 32) begin : g_bad_width
    $error("eth_stream_fcs_checker: only DATAPATH_WIDTH=32 is supported");
  end

  logic [31:0] hold_data;
  logic        hold_valid;
  logic [31:0] out_data;
  eth_keep_t   out_keep;
  logic        out_valid;
  logic        out_last;
  logic        out_abort;
  logic [31:0] crc_next;
  logic        crc_match;

  eth_fcs_crc32 u_crc (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_init     (eths_slave.last | eths_slave.abort),
    .i_en       (eths_slave.valid),
    .i_last     (eths_slave.last),
    .i_data     (eths_slave.data),
    .i_keep     (eths_slave.keep),
    .o_crc_next (crc_next),
    .o_match    (crc_match)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hold_data       <= '0;
      hold_valid      <= 1'b0;
      out_data        <= '0;
      out_keep        <= '0;
      out_valid       <= 1'b0;
      out_last        <= 1'b0;
      out_abort       <= 1'b0;
      o_good_count    <= '0;
      o_bad_fcs_count <= '0;
      o_runt_count    <= '0;
      o_abort_count   <= '0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_abort <= 1'b0;
      out_keep  <= '0;
      if (eths_slave.valid) begin
        if (eths_slave.abort) begin
          // The abort beat's own data is discarded; only the held beat survives.
          if (hold_valid) begin
            out_data  <= hold_data;
            out_keep  <= 2'd3;
            out_valid <= 1'b1;
            out_last  <= 1'b1;
            out_abort <= 1'b1;
          end
          hold_valid    <= 1'b0;
          o_abort_count <= sat_inc(o_abort_count);
        end else if (eths_slave.last) begin
          // Last beat plus the hold tail are exactly the 4 FCS bytes.
          if (hold_valid) begin
            out_data  <= hold_data;
            out_keep  <= eths_slave.keep;
            out_valid <= 1'b1;
            out_last  <= 1'b1;
            out_abort <= ~crc_match;
            if (crc_match) o_good_count    <= sat_inc(o_good_count);
            else           o_bad_fcs_count <= sat_inc(o_bad_fcs_count);
          end else begin
            o_runt_count <= sat_inc(o_runt_count);
          end
          hold_valid <= 1'b0;
        end else begin
          if (hold_valid) begin
            out_data  <= hold_data;
            out_keep  <= 2'd3;
            out_valid <= 1'b1;
          end
          hold_data  <= eths_slave.data;
          hold_valid <= 1'b1;
        end
      end
    end
  end

  assign eths_master.data  = out_data;
  assign eths_master.keep  = out_keep;
  assign eths_master.valid = out_valid;
  assign eths_master.last  = out_last;
  assign eths_master.abort = out_abort;

endmodule

// File: tb/tb_eth_stream_fcs_checker.sv
// Scoreboard bench for eth_stream_fcs_checker: expected output beats are
// queued as input beats are driven and compared as the DUT emits them.
module tb_eth_stream_fcs_checker;
  import eth_stream_pkg::*;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [31:0] data;
    eth_keep_t   keep;
    logic        last;
    logic        abort;
    int          cyc;
  } exp_beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] good_cnt, bad_cnt, runt_cnt, abort_cnt;

  eth_stream_fcs_checker_if s_if ();
  eth_stream_fcs_checker_if m_if ();

  eth_stream_fcs_checker #(.DATAPATH_WIDTH(32)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .eths_slave      (s_if),
    .eths_master     (m_if),
    .o_good_count    (good_cnt),
    .o_bad_fcs_count (bad_cnt),
    .o_runt_count    (runt_cnt),
    .o_abort_count   (abort_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  int e_good = 0, e_bad = 0, e_runt = 0, e_abort = 0;
  exp_beat_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  // Output monitor / scoreboard consumer
  exp_beat_t   mon_e;
  logic [31:0] mon_mask;
  always @(negedge clk) begin
    if (m_if.valid === 1'b1) begin
      chk("beat_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("out_last",  32'(m_if.last),  32'(mon_e.last));
        chk("out_abort", 32'(m_if.abort), 32'(mon_e.abort));
        chk("out_cycle", 32'(cyc),        32'(mon_e.cyc));
        if (mon_e.last) begin
          chk("out_keep", 32'(m_if.keep), 32'(mon_e.keep));
          mon_mask = 32'hFFFF_FFFF >> (8 * (3 - int'(mon_e.keep)));
          chk("out_data_tail", m_if.data & mon_mask, mon_e.data & mon_mask);
        end else begin
          chk("out_data", m_if.data, mon_e.data);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      s_if.valid = 1'b0;
      s_if.last  = 1'b0;
      s_if.abort = 1'b0;
    end
  endtask

  task automatic drive(input logic [31:0] d, input eth_keep_t k, input logic l, input logic a,
                       output int c);
    @(posedge clk); #1;
    s_if.data  = d;
    s_if.keep  = k;
    s_if.valid = 1'b1;
    s_if.last  = l;
    s_if.abort = a;
    c = cyc;
  endtask

  task automatic send_pkt(input byte_q_t b, input int abort_at, input bit bad, input int maxb);
    int nb, rem, c;
    logic [31:0] d, prev;
    eth_keep_t k;
    logic lst, ab;
    exp_beat_t e;
    nb = (b.size() + 3) / 4;
    prev = '0;
    for (int i = 0; i < nb; i++) begin
      if (maxb > 0) idle(int'($urandom_range(0, maxb)));
      d = '0;
      for (int j = 0; j < 4; j++)
        if (4*i + j < b.size()) d[8*j +: 8] = b[4*i + j];
      rem = b.size() - 4*i;
      if (rem > 4) rem = 4;
      k   = eth_keep_t'(rem - 1);
      lst = (i == nb - 1);
      ab  = (i == abort_at);
      drive(d, k, lst, ab, c);
      if (i > 0) begin
        e.data  = prev;
        e.keep  = ab ? 2'd3 : (lst ? k : 2'd3);
        e.last  = ab | lst;
        e.abort = ab | (lst & bad);
        e.cyc   = c + 1;
        sb.push_back(e);
      end
      if (ab) begin
        e_abort++;
        break;
      end
      if (lst) begin
        if (i == 0)   e_runt++;
        else if (bad) e_bad++;
        else          e_good++;
      end
      prev = d;
    end
  endtask

  task automatic check_counters(input string tag);
    idle(2);
    @(negedge clk);
    chk({tag, "_good"},  good_cnt,  32'(e_good));
    chk({tag, "_bad"},   bad_cnt,   32'(e_bad));
    chk({tag, "_runt"},  runt_cnt,  32'(e_runt));
    chk({tag, "_abort"}, abort_cnt, 32'(e_abort));
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(m_if.valid), 32'd0);
    chk({tag, "_last"},  32'(m_if.last),  32'd0);
    chk({tag, "_abort"}, 32'(m_if.abort), 32'd0);
    chk({tag, "_keep"},  32'(m_if.keep),  32'd0);
  endtask

  byte_q_t good_f, bad_f, runt_f, abrt_f;
  int c_unused;

  initial begin
    good_f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
               8'h26, 8'h39, 8'hF4, 8'hCB};
    bad_f = good_f;
    bad_f[4] = 8'h36;
    runt_f = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    abrt_f = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
               8'h09, 8'h0A, 8'h0B, 8'h0C};

    s_if.data = '0; s_if.keep = '0; s_if.valid = 1'b0; s_if.last = 1'b0; s_if.abort = 1'b0;

    repeat (3) @(posedge clk);
    check_idle_outputs("rst");
    chk("rst_data", m_if.data, 32'd0);
    #1 rst_n = 1'b1;
    check_counters("rst_cnt");

    send_pkt(good_f, -1, 1'b0, 0);
    check_counters("good");

    send_pkt(bad_f, -1, 1'b1, 0);
    check_counters("bad_fcs");

    send_pkt(runt_f, -1, 1'b0, 0);
    check_counters("runt");

    send_pkt(abrt_f, 1, 1'b0, 0);
    send_pkt(good_f, -1, 1'b0, 0);
    check_counters("abort");

    send_pkt(good_f, -1, 1'b0, 3);
    send_pkt(good_f, -1, 1'b0, 3);
    check_counters("b2b");

    // Reset arrives with the second beat of a partial packet.
    drive(32'h4443_4241, 2'd3, 1'b0, 1'b0, c_unused);
    drive(32'h4847_4645, 2'd3, 1'b0, 1'b0, c_unused);
    rst_n = 1'b0;
    idle(1);
    @(posedge clk); #1 rst_n = 1'b1;
    e_good = 0; e_bad = 0; e_runt = 0; e_abort = 0;
    check_idle_outputs("midrst");
    check_counters("midrst_cnt");
    send_pkt(good_f, -1, 1'b0, 0);
    check_counters("after_rst");

    idle(3);
    chk("queue_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
